// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the fetch PC, reads a combinational instruction memory,
// and queues {pc, instr} pairs in a prefetch FIFO toward decode (valid/ready).
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        fetch_busy
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [31:0]    r_pc;
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic [31:0]    r_mem_pc    [FIFO_DEPTH];
    logic [31:0]    r_mem_instr [FIFO_DEPTH];

    logic           w_push;
    logic           w_pop;
    logic           w_out_valid;
    logic           w_unused_rpc;

    // The two low redirect bits are ignored; the target is always word aligned.
    assign w_unused_rpc = ^redirect_pc[1:0];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:  w_state_nxt = fetch_en ? S_RUN : S_HALT;
            S_RUN:   if (!fetch_en) w_state_nxt = S_HALT;
            S_HALT:  if (fetch_en) w_state_nxt = S_RUN;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    assign fetch_busy = (r_state == S_RUN);

    // ------------------------------------------------------------------
    // Push / pop qualification
    // ------------------------------------------------------------------
    // Fullness uses the registered count only: a pop never frees a slot
    // for a push in the same cycle.
    assign w_out_valid = (r_count != '0);
    assign w_push      = (r_state == S_RUN) && (r_count < CW'(FIFO_DEPTH)) && !redirect_valid;
    assign w_pop       = w_out_valid && out_ready;

    // ------------------------------------------------------------------
    // Fetch PC
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC_ALIGNED;
        end else if (redirect_valid) begin
            r_pc <= {redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            r_pc <= r_pc + 32'd4;
        end
    end

    assign imem_addr = r_pc;

    // ------------------------------------------------------------------
    // Prefetch FIFO pointers and occupancy
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Prefetch FIFO storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_pc;
            r_mem_instr[r_wr_ptr] <= imem_rdata;
        end
    end

    assign out_valid = w_out_valid;
    assign out_pc    = r_mem_pc[r_rd_ptr];
    assign out_instr = r_mem_instr[r_rd_ptr];

endmodule
